// File: rtl/mips_cpu_lsu_ctrl.sv
// Purpose : multi-cycle load/store sequencer between the MEM stage and an Avalon-style data bus.
// Latency : from the request-sampling edge, load 3 cycles, store 2, rejected request 1; each waitrequest cycle adds 1.
// Backpr. : holds the bus command stable while mem_waitrequest=1 and stalls the pipeline until cpu_done.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_valid/write/op    request strobe, store flag, access opcode (LB..LWR / SB,SH,SW)
//   cpu_addr/wdata/rt_old byte address, store data, current rt for the LWL/LWR merge
//   cpu_stall/done        pipeline hold, one-cycle completion pulse
//   cpu_rdata/addr_err    registered load result, error flag (qualified by cpu_done)
//   mem_*                 Avalon-style master: word address, read/write strobes,
//                         byteenable, writedata, readdata (latency 1), waitrequest
//
// Build option: LSU_UNALIGNED_TRAP_EN - when defined, misaligned LH/LHU/SH/LW/SW are
// rejected with cpu_addr_err and no bus cycle. When undefined, halfword accesses use
// offset {addr[1],0}, word accesses ignore addr[1:0], and only illegal ops are rejected.

module mips_cpu_lsu_ctrl #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_valid,
    input  logic          cpu_write,
    input  logic [2:0]    cpu_op,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [31:0]   cpu_rt_old,
    output logic          cpu_stall,
    output logic          cpu_done,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_addr_err,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [3:0]    mem_byteenable,
    output logic [31:0]   mem_writedata,
    input  logic [31:0]   mem_readdata,
    input  logic          mem_waitrequest
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [2:0] OP_B   = 3'b000;
    localparam logic [2:0] OP_BU  = 3'b001;
    localparam logic [2:0] OP_H   = 3'b010;
    localparam logic [2:0] OP_HU  = 3'b011;
    localparam logic [2:0] OP_BAD = 3'b100;
    localparam logic [2:0] OP_W   = 3'b101;
    localparam logic [2:0] OP_WL  = 3'b110;
    localparam logic [2:0] OP_WR  = 3'b111;

    state_t state, state_nxt;

    // Request latched in IDLE; everything the access needs lives here so the
    // cpu_* inputs may change freely once the request has been taken.
    logic          wr_q;
    logic [2:0]    op_q;
    logic [1:0]    k_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wd_q;
    logic [31:0]   rt_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    // ------------------------------------------------------------------
    // Request decode (combinational on cpu_* inputs, used only in IDLE)
    // ------------------------------------------------------------------
    logic        req_take;
    logic        req_is_half;
    logic        req_is_word;
    logic        req_illegal;
    logic        req_misalign;
    logic        req_err;
    logic [1:0]  req_k;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    always_comb begin
        req_is_half  = (cpu_op == OP_H) || (cpu_op == OP_HU);
        req_is_word  = (cpu_op == OP_W);
        req_illegal  = (cpu_op == OP_BAD) ||
                       (cpu_write && !((cpu_op == OP_B) || (cpu_op == OP_H) || (cpu_op == OP_W)));
`ifdef LSU_UNALIGNED_TRAP_EN
        req_misalign = (req_is_half && cpu_addr[0]) ||
                       (req_is_word && (cpu_addr[1:0] != 2'b00));
`else
        req_misalign = 1'b0;
`endif
        req_err = req_illegal || req_misalign;

        // Effective byte offset: halfwords snap to an even lane pair, words to
        // lane 0. With the trap enabled the dropped bits are already known zero.
        if (req_is_word) begin
            req_k = 2'b00;
        end else if (req_is_half) begin
            req_k = {cpu_addr[1], 1'b0};
        end else begin
            req_k = cpu_addr[1:0];
        end

        req_be = 4'b1111;
        req_wd = cpu_wdata;
        if (cpu_write) begin
            case (cpu_op)
                OP_B: begin
                    req_be = 4'b0001 << req_k;
                    req_wd = {4{cpu_wdata[7:0]}};
                end
                OP_H: begin
                    req_be = req_k[1] ? 4'b1100 : 4'b0011;
                    req_wd = {2{cpu_wdata[15:0]}};
                end
                default: begin
                    req_be = 4'b1111;
                    req_wd = cpu_wdata;
                end
            endcase
        end
    end

    assign req_take = (state == IDLE) && cpu_valid;

    // ------------------------------------------------------------------
    // Load result: lane extraction, extension and LWL/LWR merge
    // ------------------------------------------------------------------
    logic [31:0] rd_shr;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] load_res;

    always_comb begin
        lwr_sh   = {k_q, 3'b000};
        // 8*(3-k) == 8*~k for a 2-bit k
        lwl_sh   = {~k_q, 3'b000};
        rd_shr   = mem_readdata >> lwr_sh;
        load_res = mem_readdata;
        case (op_q)
            OP_B:    load_res = {{24{rd_shr[7]}}, rd_shr[7:0]};
            OP_BU:   load_res = {24'h000000, rd_shr[7:0]};
            OP_H:    load_res = {{16{rd_shr[15]}}, rd_shr[15:0]};
            OP_HU:   load_res = {16'h0000, rd_shr[15:0]};
            OP_W:    load_res = mem_readdata;
            // LWL keeps the low 8*(3-k) bits of rt; k=3 degenerates to a plain load
            OP_WL:   load_res = (mem_readdata << lwl_sh) | (rt_q & ~(32'hFFFF_FFFF << lwl_sh));
            // LWR keeps the high 8*k bits of rt; k=0 degenerates to a plain load
            OP_WR:   load_res = rd_shr | (rt_q & ~(32'hFFFF_FFFF >> lwr_sh));
            default: load_res = mem_readdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_valid) begin
                    state_nxt = req_err ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_waitrequest) begin
                    state_nxt = wr_q ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= 1'b0;
            op_q   <= 3'b000;
            k_q    <= 2'b00;
            addr_q <= '0;
            be_q   <= 4'b0000;
            wd_q   <= 32'h0;
            rt_q   <= 32'h0;
            err_q  <= 1'b0;
        end else if (req_take) begin
            wr_q   <= cpu_write;
            op_q   <= cpu_op;
            k_q    <= req_k;
            addr_q <= {cpu_addr[AW-1:2], 2'b00};
            be_q   <= req_be;
            wd_q   <= req_wd;
            rt_q   <= cpu_rt_old;
            err_q  <= req_err;
        end
    end

    // Only a completed read updates the result; rejected requests and stores
    // leave the previous load value visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (state == WAIT_DATA) begin
            rdata_q <= load_res;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign cpu_done       = (state == DONE);
    assign cpu_addr_err   = cpu_done && err_q;
    assign cpu_stall      = cpu_valid && !cpu_done;
    assign cpu_rdata      = rdata_q;
    assign mem_read       = (state == ACCESS) && !wr_q;
    assign mem_write      = (state == ACCESS) && wr_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wd_q;

endmodule

// File: tb/tb_mips_cpu_lsu_ctrl.sv
// Purpose : randomized scoreboard bench for mips_cpu_lsu_ctrl against a behavioural model.
// Latency : the monitor checks completion latency relative to the request-sampling edge.
// Backpr. : a bus responder inserts a planned number of waitrequest cycles per access.

module tb_mips_cpu_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_write;
    logic [2:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rt_old;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_addr_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    mips_cpu_lsu_ctrl #(.AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_valid      (cpu_valid),
        .cpu_write      (cpu_write),
        .cpu_op         (cpu_op),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rt_old     (cpu_rt_old),
        .cpu_stall      (cpu_stall),
        .cpu_done       (cpu_done),
        .cpu_rdata      (cpu_rdata),
        .cpu_addr_err   (cpu_addr_err),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat;
        int          start;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          wait_left = 0;
    logic [31:0] cur_w = 32'h0;
    logic [31:0] model_rdata = 32'h0;

    assign mem_waitrequest = (wait_left != 0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model written straight from the access rules.
    function automatic exp_t model(input logic wr, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rt,
                                   input logic [31:0] w, input int nw);
        exp_t        e;
        int          k;
        int          sh;
        logic        half;
        logic        word;
        logic        bad;
        logic [31:0] b;
        logic [31:0] h;
        logic [63:0] mask;
        k    = int'(a % 4);
        half = (op == 3'd2) || (op == 3'd3);
        word = (op == 3'd5);
        bad  = (op == 3'd4) || (wr && !(op == 3'd0 || op == 3'd2 || op == 3'd5));
`ifdef LSU_UNALIGNED_TRAP_EN
        if ((half && (k % 2) != 0) || (word && k != 0)) bad = 1'b1;
`endif
        if (half) k = k - (k % 2);
        if (word) k = 0;
        e.wr    = wr;
        e.err   = bad;
        e.addr  = a - (a % 4);
        e.be    = 4'hF;
        e.wd    = wd;
        e.rdata = 32'h0;
        b = (w >> (8 * k)) % 256;
        h = (w >> (8 * k)) % 65536;
        if (!wr) begin
            case (op)
                3'd0: e.rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                3'd1: e.rdata = b;
                3'd2: e.rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                3'd3: e.rdata = h;
                3'd6: begin
                    sh      = 8 * (3 - k);
                    mask    = (64'd1 << sh) - 64'd1;
                    e.rdata = (w << sh) | (rt & mask[31:0]);
                end
                3'd7: e.rdata = (w >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
                default: e.rdata = w;
            endcase
        end else begin
            case (op)
                3'd0: begin e.be = 4'(1 << k); e.wd = (wd % 256) * 32'h0101_0101; end
                3'd2: begin e.be = (k == 0) ? 4'h3 : 4'hC; e.wd = (wd % 65536) * 32'h0001_0001; end
                default: begin e.be = 4'hF; e.wd = wd; end
            endcase
        end
        e.lat   = bad ? 1 : (wr ? 2 + nw : 3 + nw);
        e.start = 0;
        return e;
    endfunction

    // Bus responder: holds waitrequest for the planned cycles, then returns
    // cur_w only in the cycle after an accepted read (garbage otherwise).
    initial begin
        logic strobe;
        logic rd;
        int   wl;
        mem_readdata = 32'h0;
        forever begin
            @(negedge clk);
            strobe = mem_read || mem_write;
            rd     = mem_read;
            wl     = wait_left;
            @(posedge clk);
            #1;
            mem_readdata = $urandom;
            if (strobe && !reset) begin
                if (wl > 0) wait_left = wl - 1;
                else if (rd) mem_readdata = cur_w;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            chk("stall", {31'b0, cpu_stall}, {31'b0, cpu_valid & ~cpu_done});
            if (mem_read || mem_write) begin
                if (expq.size() == 0) begin
                    chk("bus_unexpected", {30'b0, mem_read, mem_write}, 32'h0);
                end else begin
                    chk("bus_on_err", {31'b0, expq[0].err}, 32'h0);
                    chk("bus_read", {31'b0, mem_read}, {31'b0, ~expq[0].wr});
                    chk("bus_write", {31'b0, mem_write}, {31'b0, expq[0].wr});
                    chk("bus_addr", mem_address, expq[0].addr);
                    chk("bus_be", {28'b0, mem_byteenable}, {28'b0, expq[0].be});
                    if (expq[0].wr) chk("bus_wdata", mem_writedata, expq[0].wd);
                end
            end
            if (cpu_done) begin
                if (expq.size() == 0) begin
                    chk("done_unexpected", 32'h1, 32'h0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("addr_err", {31'b0, cpu_addr_err}, {31'b0, mon_e.err});
                    chk("latency", cyc - mon_e.start + 1, mon_e.lat);
                    if (!mon_e.err && !mon_e.wr) model_rdata = mon_e.rdata;
                    chk("rdata", cpu_rdata, model_rdata);
                end
            end else begin
                chk("err_idle", {31'b0, cpu_addr_err}, 32'h0);
                chk("rdata_hold", cpu_rdata, model_rdata);
            end
        end
    end

    task automatic do_reset_pulse();
        reset = 1'b1;
        cpu_valid = 1'b0;
        expq.delete();
        model_rdata = 32'h0;
        wait_left = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rt,
                          input logic [31:0] w, input int nw);
        exp_t e;
        logic got;
        e = model(wr, op, a, wd, rt, w, nw);
        e.start    = cyc + 1;
        cur_w      = w;
        wait_left  = e.err ? 0 : nw;
        cpu_write  = wr;
        cpu_op     = op;
        cpu_addr   = a;
        cpu_wdata  = wd;
        cpu_rt_old = rt;
        cpu_valid  = 1'b1;
        expq.push_back(e);
        @(posedge clk);
        #1;
        // Request is latched now; scramble the inputs to show they are ignored.
        cpu_write  = $urandom;
        cpu_op     = $urandom;
        cpu_addr   = $urandom;
        cpu_wdata  = $urandom;
        cpu_rt_old = $urandom;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'h0, 32'h1);
            do_reset_pulse();
        end else begin
            @(posedge clk);
            #1 cpu_valid = 1'b0;
        end
    endtask

    initial begin
        logic got;
        reset      = 1'b1;
        cpu_valid  = 1'b0;
        cpu_write  = 1'b0;
        cpu_op     = 3'b000;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_rt_old = 32'h0;
        #12;
        chk("rst_done", {31'b0, cpu_done}, 32'h0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_err", {31'b0, cpu_addr_err}, 32'h0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_be", {28'b0, mem_byteenable}, 32'h0);
        chk("rst_wdata", mem_writedata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        do_req(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h0, 32'h80FF_1234, 0);
        do_req(1'b0, 3'd3, 32'h0000_0102, 32'h0, 32'h0, 32'hBEEF_0000, 2);
        do_req(1'b0, 3'd6, 32'h0000_0301, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        do_req(1'b0, 3'd7, 32'h0000_0301, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 1);
        do_req(1'b1, 3'd0, 32'h0000_0201, 32'h0000_005A, 32'h0, 32'h0, 0);
        do_req(1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h0, 32'h1357_9BDF, 0);
        do_req(1'b0, 3'd4, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0);
        do_req(1'b1, 3'd1, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 0);
        do_req(1'b1, 3'd2, 32'h0000_0402, 32'h1234_ABCD, 32'h0, 32'h0, 1);
        do_req(1'b1, 3'd5, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 32'h0, 3);

        // Reset while the read data is in flight
        cur_w      = 32'hDEAD_BEEF;
        wait_left  = 1;
        cpu_write  = 1'b0;
        cpu_op     = 3'd5;
        cpu_addr   = 32'h0000_0040;
        cpu_valid  = 1'b1;
        expq.push_back(model(1'b0, 3'd5, 32'h0000_0040, 32'h0, 32'h0, 32'hDEAD_BEEF, 1));
        expq[0].start = cyc + 1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_read && !mem_waitrequest) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("rst_test_accept", 32'h0, 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("midrst_done", {31'b0, cpu_done}, 32'h0);
        chk("midrst_rdata", cpu_rdata, 32'h0);
        do_reset_pulse();
        @(posedge clk);
        #1;
        do_req(1'b0, 3'd5, 32'h0000_0080, 32'h0, 32'h0, 32'h0BAD_CAFE, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin
                cpu_write = $urandom;
                cpu_op    = $urandom;
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("drain", expq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
